// File: rtl/proj_extender_stream.sv
// Streaming fragment extender: one accepted fragment is replayed as BEATS
// multi-lane beats per valid k-mer index, tagged with the centre-adjusted index.
module proj_extender_stream #(
  parameter int FRAG_LEN_BITS     = 512,
  parameter int FRAG_SIZE         = 256,
  parameter int KMER_SIZE         = 16,
  parameter int INDICES_COUNT     = 8,
  parameter int INDICE_LEN        = 16,
  parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1,
  parameter int FRAG_PART         = 64,
  parameter int LANES             = 2,
  parameter int CNT_W             = $clog2(INDICES_COUNT) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [FRAG_LEN_BITS-1:0]            in_fragment,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_kmer_indices,
  input  logic [CNT_W-1:0]                    in_count,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SIGNED_INDICE_LEN-1:0]        out_index,
  output logic [FRAG_PART*LANES-1:0]          out_gfm,
  output logic                                out_first,
  output logic                                out_last
);

  localparam int GFM_W  = FRAG_PART * LANES;
  localparam int BEATS  = FRAG_LEN_BITS / GFM_W;
  localparam int OFFSET = (FRAG_SIZE - KMER_SIZE) >> 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SEL_W  = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;

  localparam logic [BEAT_W-1:0]            LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]             MAX_CNT   = CNT_W'(INDICES_COUNT);
  localparam logic [SIGNED_INDICE_LEN-1:0] OFFSET_V  = SIGNED_INDICE_LEN'(OFFSET);

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_STREAM = 1'b1;

  logic                                state_q, state_d;
  logic [FRAG_LEN_BITS-1:0]            frag_q, frag_d;
  logic [INDICES_COUNT*INDICE_LEN-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [BEAT_W-1:0]                   beat_q, beat_d;
  logic [SEL_W-1:0]                    sel_q, sel_d;

  logic [CNT_W-1:0]      in_cnt_sat;
  logic                  last_sel;
  logic [INDICE_LEN-1:0] cur_idx;

  assign in_cnt_sat = (in_count > MAX_CNT) ? MAX_CNT : in_count;
  assign last_sel   = (CNT_W'(sel_q) == cnt_q - 1'b1);
  assign cur_idx    = idx_q[int'(sel_q)*INDICE_LEN +: INDICE_LEN];

  // Outputs come only from registers; in_ready additionally masks the reset cycle.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_STREAM);
    out_gfm   = '0;
    out_index = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_gfm   = frag_q[int'(beat_q)*GFM_W +: GFM_W];
      out_index = {1'b0, cur_idx} - OFFSET_V;
      out_first = (beat_q == '0);
      out_last  = (beat_q == LAST_BEAT) && last_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    frag_d  = frag_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    sel_d   = sel_q;
    if (state_q == S_IDLE) begin
      if (in_valid && in_ready) begin
        frag_d  = in_fragment;
        idx_d   = in_kmer_indices;
        cnt_d   = in_cnt_sat;
        beat_d  = '0;
        sel_d   = '0;
        if (in_cnt_sat != '0) begin
          state_d = S_STREAM;
        end
      end
    end else if (out_ready) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        sel_d  = sel_q + 1'b1;
        if (last_sel) begin
          state_d = S_IDLE;
        end
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      frag_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      frag_q  <= frag_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_proj_extender_stream.sv
// Directed bench for proj_extender_stream: reset, streaming, back-pressure,
// count edge cases, mid-stream reset and index boundary values.
module tb_proj_extender_stream;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_fragment;
  logic [127:0] in_kmer_indices;
  logic [3:0]   in_count;
  logic         out_valid;
  logic         out_ready;
  logic [16:0]  out_index;
  logic [127:0] out_gfm;
  logic         out_first;
  logic         out_last;

  int checks;
  int failures;

  logic [127:0] b_gfm   [0:63];
  logic [16:0]  b_idx   [0:63];
  logic         b_first [0:63];
  logic         b_last  [0:63];
  int           nb;

  logic [511:0] frag_a;
  logic [511:0] frag_b;

  proj_extender_stream #(
    .FRAG_LEN_BITS(512),
    .FRAG_SIZE(256),
    .KMER_SIZE(16),
    .INDICES_COUNT(8),
    .INDICE_LEN(16),
    .FRAG_PART(64),
    .LANES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_fragment(in_fragment),
    .in_kmer_indices(in_kmer_indices),
    .in_count(in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_gfm(out_gfm),
    .out_first(out_first),
    .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] f, input logic [127:0] k, input logic [3:0] c);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_wait in_ready=%0b required=1", in_ready);
    end
    checks++;
    in_fragment     = f;
    in_kmer_indices = k;
    in_count        = c;
    in_valid        = 1'b1;
    tick();
    in_valid        = 1'b0;
  endtask

  task automatic collect(input int max_cycles);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 0;
    nb   = 0;
    while (!done && cyc < max_cycles) begin
      out_ready = 1'b1;
      if (out_valid && out_ready) begin
        b_gfm[nb]   = out_gfm;
        b_idx[nb]   = out_index;
        b_first[nb] = out_first;
        b_last[nb]  = out_last;
        nb++;
        if (out_last || nb == 64) done = 1;
      end
      tick();
      cyc++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL collect_timeout beats=%0d last_seen=0 required=1", nb);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
      end
      checks++;
      if ({out_valid, out_first, out_last} !== 3'b000 || out_gfm !== '0 || out_index !== '0) begin
        failures++;
        $display("FAIL reset_outputs got=v%0b g%h i%h exp=0", out_valid, out_gfm, out_index);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_gfm !== '0 || out_index !== '0) begin
      failures++;
      $display("FAIL reset_release_out got=v%0b g%h i%h exp=0", out_valid, out_gfm, out_index);
    end
  endtask

  task automatic test_single;
    logic [127:0] k;
    logic [127:0] eg;
    logic [16:0]  ei;
    k = '0;
    k[15:0]  = 16'd500;
    k[31:16] = 16'd100;
    send(frag_a, k, 4'd2);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency out_valid=%0b exp=1", out_valid);
    end
    collect(40);
    checks++;
    if (nb != 8) begin
      failures++;
      $display("FAIL single_beats got=%0d exp=8", nb);
    end
    for (int b = 0; b < 8; b++) begin
      eg = frag_a[(b % 4)*128 +: 128];
      ei = (b < 4) ? 17'h0017C : 17'h1FFEC;
      checks++;
      if (b_gfm[b] !== eg || b_idx[b] !== ei) begin
        failures++;
        $display("FAIL single_beat%0d got=g%h i%h exp=g%h i%h", b, b_gfm[b], b_idx[b], eg, ei);
      end
      checks++;
      if (b_first[b] !== (b % 4 == 0) || b_last[b] !== (b == 7)) begin
        failures++;
        $display("FAIL single_flags%0d got=f%0b l%0b exp=f%0b l%0b", b, b_first[b], b_last[b], b % 4 == 0, b == 7);
      end
    end
    checks++;
    if (b_gfm[1] !== frag_a[255:128]) begin
      failures++;
      $display("FAIL single_beat1_slice got=%h exp=%h", b_gfm[1], frag_a[255:128]);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_turnaround got=r%0b v%0b exp=r1 v0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_pressure;
    logic [127:0] k;
    logic [147:0] prev_vec;
    logic [147:0] cur_vec;
    logic [127:0] eg;
    logic [16:0]  ei;
    bit           have_prev;
    bit           done;
    int           cyc;
    k = '0;
    k[15:0]  = 16'd500;
    k[31:16] = 16'd100;
    send(frag_a, k, 4'd2);
    cyc = 0;
    nb = 0;
    done = 0;
    have_prev = 0;
    prev_vec = '0;
    while (!done && cyc < 100) begin
      out_ready = (cyc % 3 == 0);
      cur_vec = {out_valid, out_first, out_last, out_index, out_gfm};
      if (have_prev) begin
        checks++;
        if (cur_vec !== prev_vec) begin
          failures++;
          $display("FAIL bp_stall_hold cyc=%0d got=%h exp=%h", cyc, cur_vec, prev_vec);
        end
      end
      if (out_valid && out_ready && nb < 64) begin
        b_gfm[nb] = out_gfm;
        b_idx[nb] = out_index;
        b_first[nb] = out_first;
        b_last[nb] = out_last;
        nb++;
        if (out_last) done = 1;
      end
      have_prev = out_valid && !out_ready;
      prev_vec = cur_vec;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (nb != 8 || !done) begin
      failures++;
      $display("FAIL bp_beats got=%0d exp=8", nb);
    end
    for (int b = 0; b < 8; b++) begin
      eg = frag_a[(b % 4)*128 +: 128];
      ei = (b < 4) ? 17'h0017C : 17'h1FFEC;
      checks++;
      if (b_gfm[b] !== eg || b_idx[b] !== ei || b_last[b] !== (b == 7)) begin
        failures++;
        $display("FAIL bp_beat%0d got=g%h i%h l%0b exp=g%h i%h l%0b", b, b_gfm[b], b_idx[b], b_last[b], eg, ei, b == 7);
      end
    end
  endtask

  task automatic test_zero_sat;
    logic [127:0] k;
    logic [16:0]  ei;
    send(frag_a, 128'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL zero_count_idle got=v%0b r%0b exp=v0 r1", out_valid, in_ready);
      end
      tick();
    end
    k = '0;
    for (int j = 0; j < 8; j++) k[j*16 +: 16] = 16'(200 + 10*j);
    send(frag_a, k, 4'd15);
    collect(100);
    checks++;
    if (nb != 32) begin
      failures++;
      $display("FAIL sat_beats got=%0d exp=32", nb);
    end
    for (int b = 0; b < 32; b++) begin
      ei = 17'(80 + 10*(b / 4));
      checks++;
      if (b_idx[b] !== ei || b_last[b] !== (b == 31) || b_first[b] !== (b % 4 == 0)) begin
        failures++;
        $display("FAIL sat_beat%0d got=i%h f%0b l%0b exp=i%h f%0b l%0b", b, b_idx[b], b_first[b], b_last[b], ei, b % 4 == 0, b == 31);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [127:0] k;
    k = '0;
    k[15:0]  = 16'd500;
    k[31:16] = 16'd100;
    send(frag_a, k, 4'd2);
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_gfm !== frag_a[383:256] || out_first !== 1'b0) begin
      failures++;
      $display("FAIL midrst_beat2 got=v%0b g%h f%0b exp=v1 g%h f0", out_valid, out_gfm, out_first, frag_a[383:256]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_first, out_last} !== 3'b000 || out_gfm !== '0 || out_index !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=v%0b f%0b l%0b exp=0", out_valid, out_first, out_last);
    end
    rst = 1'b0;
    k = '0;
    k[15:0] = 16'd300;
    send(frag_b, k, 4'd1);
    collect(40);
    checks++;
    if (nb != 4) begin
      failures++;
      $display("FAIL midrst_beats got=%0d exp=4", nb);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (b_gfm[b] !== frag_b[b*128 +: 128] || b_idx[b] !== 17'd180 || b_first[b] !== (b == 0) || b_last[b] !== (b == 3)) begin
        failures++;
        $display("FAIL midrst_beat%0d got=g%h i%h f%0b l%0b exp=g%h i%h", b, b_gfm[b], b_idx[b], b_first[b], b_last[b], frag_b[b*128 +: 128], 17'd180);
      end
    end
  endtask

  task automatic test_boundary;
    logic [127:0] k;
    logic [16:0]  ei;
    k = '0;
    k[15:0]  = 16'd120;
    k[31:16] = 16'd65535;
    k[47:32] = 16'd0;
    send(frag_b, k, 4'd3);
    collect(60);
    checks++;
    if (nb != 12) begin
      failures++;
      $display("FAIL bound_beats got=%0d exp=12", nb);
    end
    for (int b = 0; b < 12; b++) begin
      ei = (b < 4) ? 17'h00000 : (b < 8) ? 17'h0FF87 : 17'h1FF88;
      checks++;
      if (b_idx[b] !== ei) begin
        failures++;
        $display("FAIL bound_index%0d got=%h exp=%h", b, b_idx[b], ei);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_fragment = '0;
    in_kmer_indices = '0;
    in_count = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      frag_a[i*8 +: 8] = 8'(i);
      frag_b[i*8 +: 8] = 8'(i) ^ 8'hA5;
    end
    test_reset();
    test_single();
    test_back_pressure();
    test_zero_sat();
    test_mid_reset();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
